// File: rtl/seq_detector_param.sv
// Serial sequence detector with a runtime-programmable pattern of 1..MAX_LEN bits.
// Supports overlapping and non-overlapping detection, a valid strobe, and a saturating
// match counter. The first expected bit of a pattern is bit [len-1]; the last is bit [0].
module seq_detector_param #(
    parameter int unsigned         MAX_LEN     = 8,
    parameter int unsigned         CNT_W       = 8,
    parameter logic [MAX_LEN-1:0]  DEF_PATTERN = MAX_LEN'('h16),
    parameter int unsigned         DEF_LEN     = 5,
    parameter bit                  DEF_OVERLAP = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bit_valid,
    input  logic                      seq_bit,
    input  logic                      cfg_load,
    input  logic [MAX_LEN-1:0]        cfg_pattern,
    input  logic [$clog2(MAX_LEN):0]  cfg_len,
    input  logic                      cfg_overlap,
    input  logic                      cnt_clr,
    output logic                      seq_jug,
    output logic [CNT_W-1:0]          match_cnt,
    output logic                      cnt_sat,
    output logic [1:0]                state
);

    localparam int unsigned LEN_W     = $clog2(MAX_LEN) + 1;
    localparam int unsigned RST_LEN_I = (DEF_LEN > MAX_LEN) ? MAX_LEN : DEF_LEN;

    localparam logic [LEN_W-1:0] RST_LEN   = LEN_W'(RST_LEN_I);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_DIS   = 2'd0,
        ST_FILL  = 2'd1,
        ST_ARMED = 2'd2
    } state_e;

    localparam state_e RST_STATE = (RST_LEN_I == 0) ? ST_DIS : ST_FILL;

    // Configuration registers
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q,     len_d;
    logic               overlap_q, overlap_d;

    // Detection datapath registers
    logic [MAX_LEN-1:0] history_q, history_d;
    logic [LEN_W-1:0]   fill_q,    fill_d;
    state_e             state_q,   state_d;

    // Output registers
    logic               seq_jug_q,   seq_jug_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic               cnt_sat_q,   cnt_sat_d;

    // Helper combinational terms
    logic [MAX_LEN-1:0] len_mask_c;
    logic [MAX_LEN-1:0] window_c;
    logic [LEN_W-1:0]   fill_inc_c;
    logic [LEN_W-1:0]   cfg_len_clamp_c;
    logic               bit_take_c;
    logic               pat_hit_c;
    logic               match_c;

    // Mask selecting the active low-order len bits of pattern and window
    always_comb begin
        len_mask_c = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask_c[i] = (LEN_W'(i) < len_q);
        end
    end

    // Match evaluation for the bit being presented this cycle
    always_comb begin
        window_c        = {history_q[MAX_LEN-2:0], seq_bit};
        pat_hit_c       = (((window_c ^ pattern_q) & len_mask_c) == '0);
        fill_inc_c      = (fill_q >= len_q) ? len_q : (fill_q + LEN_W'(1));
        bit_take_c      = bit_valid && (state_q != ST_DIS);
        match_c         = bit_take_c && (fill_inc_c == len_q) && pat_hit_c;
        cfg_len_clamp_c = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
    end

    // Next-state and next-output logic; cfg_load wins over bit and counter-clear inputs
    always_comb begin
        pattern_d   = pattern_q;
        len_d       = len_q;
        overlap_d   = overlap_q;
        history_d   = history_q;
        fill_d      = fill_q;
        state_d     = state_q;
        seq_jug_d   = 1'b0;
        match_cnt_d = match_cnt_q;

        if (cfg_load) begin
            pattern_d   = cfg_pattern;
            len_d       = cfg_len_clamp_c;
            overlap_d   = cfg_overlap;
            history_d   = '0;
            fill_d      = '0;
            match_cnt_d = '0;
            state_d     = (cfg_len_clamp_c == '0) ? ST_DIS : ST_FILL;
        end else begin
            if (bit_take_c) begin
                history_d = window_c;
                if (match_c && !overlap_q) begin
                    // Non-overlap: a full fresh pattern is needed before the next match
                    fill_d  = '0;
                    state_d = ST_FILL;
                end else begin
                    fill_d  = fill_inc_c;
                    state_d = (fill_inc_c == len_q) ? ST_ARMED : ST_FILL;
                end
            end

            seq_jug_d = match_c;

            if (cnt_clr) begin
                match_cnt_d = match_c ? CNT_ONE : '0;
            end else if (match_c && (match_cnt_q != CNT_MAX)) begin
                match_cnt_d = match_cnt_q + CNT_ONE;
            end
        end

        cnt_sat_d = (match_cnt_d == CNT_MAX);
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q   <= DEF_PATTERN;
            len_q       <= RST_LEN;
            overlap_q   <= DEF_OVERLAP;
            history_q   <= '0;
            fill_q      <= '0;
            state_q     <= RST_STATE;
            seq_jug_q   <= 1'b0;
            match_cnt_q <= '0;
            cnt_sat_q   <= 1'b0;
        end else begin
            pattern_q   <= pattern_d;
            len_q       <= len_d;
            overlap_q   <= overlap_d;
            history_q   <= history_d;
            fill_q      <= fill_d;
            state_q     <= state_d;
            seq_jug_q   <= seq_jug_d;
            match_cnt_q <= match_cnt_d;
            cnt_sat_q   <= cnt_sat_d;
        end
    end

    assign seq_jug   = seq_jug_q;
    assign match_cnt = match_cnt_q;
    assign cnt_sat   = cnt_sat_q;
    assign state     = state_q;

    // Structural invariants of the detector
    a_sat_consistent: assert property (@(posedge clk) disable iff (rst)
        cnt_sat_q == (match_cnt_q == CNT_MAX));
    a_fill_bound: assert property (@(posedge clk) disable iff (rst)
        fill_q <= len_q);
    a_state_fill: assert property (@(posedge clk) disable iff (rst)
        (state_q != ST_DIS) |-> ((state_q == ST_ARMED) == (fill_q == len_q)));

endmodule
